// File: rtl/key_sched_seq.sv
// rtl/key_sched_seq.sv - iterative AES-128 key expansion with an 11-entry round-key buffer
//
// Expands one round key per clock and stores round keys 0..10 for random
// read-out through a registered read port.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   key_in     in   cipher key, word 0 in the top 32 bits
//   key_valid  in   key_in valid this cycle
//   key_ready  out  high while idle; a key is taken when key_valid & key_ready
//   rd_round   in   round-key index to read (0..10; 11..15 read as zero)
//   rd_key     out  registered round key for rd_round (1-cycle latency)
//   busy       out  expansion in progress
//   done       out  one-cycle pulse on the cycle after round key 10 is stored
//   keys_ready out  level; buffer holds a complete schedule for the last key
module key_sched_seq #(
    parameter int KEY_LEN  = 128,
    parameter int WORD_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [3:0]         rd_round,
    output logic [KEY_LEN-1:0] rd_key,
    output logic               busy,
    output logic               done,
    output logic               keys_ready
);

    localparam int NUM_KEYS  = 11;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]         rnd;
    logic [KEY_LEN-1:0] work;
    logic [KEY_LEN-1:0] round_out;
    logic               accept;
    logic               step;

    logic [KEY_LEN-1:0] key_buf [0:NUM_KEYS-1];

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX_TABLE[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [WORD_LEN-1:0] sub_rot_word(input logic [WORD_LEN-1:0] w);
        logic [WORD_LEN-1:0] rot;
        logic [WORD_LEN-1:0] sub;
        rot = {w[WORD_LEN-9:0], w[WORD_LEN-1 -: 8]};
        sub = '0;
        for (int i = 0; i < WORD_LEN / 8; i++) begin
            sub[i*8 +: 8] = sbox(rot[i*8 +: 8]);
        end
        return sub;
    endfunction

    function automatic logic [KEY_LEN-1:0] next_round(input logic [KEY_LEN-1:0] prev,
                                                      input logic [7:0]         rc);
        logic [WORD_LEN-1:0] w0, w1, w2, w3, w4, w5, w6, w7;
        w0 = prev[KEY_LEN-1            -: WORD_LEN];
        w1 = prev[KEY_LEN-1-WORD_LEN   -: WORD_LEN];
        w2 = prev[KEY_LEN-1-2*WORD_LEN -: WORD_LEN];
        w3 = prev[KEY_LEN-1-3*WORD_LEN -: WORD_LEN];
        w4 = w0 ^ sub_rot_word(w3) ^ {rc, {(WORD_LEN-8){1'b0}}};
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    // The previous round key comes from the working register, so the buffer
    // only needs a write port plus the single read port.
    assign round_out = next_round(work, rcon(rnd));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    accept     = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                busy = 1'b1;
                step = 1'b1;
                if (rnd == LAST_ROUND) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd        <= '0;
            work       <= '0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
            rd_key     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                work       <= key_in;
                rnd        <= 4'd1;
                keys_ready <= 1'b0;
            end else if (step) begin
                work <= round_out;
                if (rnd == LAST_ROUND) begin
                    rnd        <= '0;
                    done       <= 1'b1;
                    keys_ready <= 1'b1;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
            // Reads see the buffer contents from before this edge's write.
            if (rd_round <= LAST_ROUND) begin
                rd_key <= key_buf[rd_round];
            end else begin
                rd_key <= '0;
            end
        end
    end

    // Buffer is not reset; keys_ready=0 marks its contents invalid.
    always_ff @(posedge clk) begin
        if (accept) begin
            key_buf[0] <= key_in;
        end else if (step) begin
            key_buf[rnd] <= round_out;
        end
    end

endmodule

// File: tb/tb_key_sched_seq.sv
// tb/tb_key_sched_seq.sv - directed self-checking bench for key_sched_seq
module tb_key_sched_seq;

    logic         clk;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         busy;
    logic         done;
    logic         keys_ready;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    key_sched_seq #(.KEY_LEN(128), .WORD_LEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .busy       (busy),
        .done       (done),
        .keys_ready (keys_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a key for exactly one edge; returns just after that edge.
    task automatic start(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_chk(input logic [3:0] r, input logic [127:0] exp, input string tag);
        rd_round = r;
        tick();
        check(tag, rd_key, exp);
    endtask

    initial begin
        int cyc;
        int dn;

        reset     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rd_round  = '0;

        #12;
        check("rst_key_ready",  128'(key_ready),  128'd1);
        check("rst_busy",       128'(busy),       128'd0);
        check("rst_done",       128'(done),       128'd0);
        check("rst_keys_ready", 128'(keys_ready), 128'd0);
        check("rst_rd_key",     rd_key,           128'd0);
        tick();
        reset = 1'b1;

        // Key 1: basic expansion and latency.
        start(K1);
        check("k1_busy",      128'(busy),       128'd1);
        check("k1_key_ready", 128'(key_ready),  128'd0);
        wait_done(cyc);
        check("k1_latency",   128'(cyc),        128'd10);
        check("k1_keys_rdy",  128'(keys_ready), 128'd1);
        check("k1_idle",      128'(key_ready),  128'd1);
        tick();
        check("k1_done_pulse", 128'(done),      128'd0);
        read_chk(4'd0,  K1,     "k1_r0");
        read_chk(4'd1,  K1_R1,  "k1_r1");
        read_chk(4'd2,  K1_R2,  "k1_r2");
        read_chk(4'd10, K1_R10, "k1_r10");

        // Key 2.
        start(K2);
        check("k2_keys_rdy_clr", 128'(keys_ready), 128'd0);
        wait_done(cyc);
        check("k2_latency", 128'(cyc), 128'd10);
        read_chk(4'd0,  K2,     "k2_r0");
        read_chk(4'd1,  K2_R1,  "k2_r1");
        read_chk(4'd10, K2_R10, "k2_r10");

        // A key offered during expansion is ignored.
        start(K1);
        tick();
        tick();
        key_in    = K2;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_done(cyc);
        check("ign_latency", 128'(cyc + 3), 128'd10);
        read_chk(4'd1,  K1_R1,  "ign_r1");
        read_chk(4'd10, K1_R10, "ign_r10");

        // Back-to-back with key_valid held high.
        key_in    = K1;
        key_valid = 1'b1;
        tick();
        key_in = K2;
        wait_done(cyc);
        check("b2b_first_latency", 128'(cyc), 128'd10);
        tick();
        key_valid = 1'b0;
        check("b2b_second_busy",    128'(busy),       128'd1);
        check("b2b_keys_rdy_clear", 128'(keys_ready), 128'd0);
        cyc = 0;
        while (!keys_ready && cyc < 30) begin
            tick();
            cyc++;
        end
        check("b2b_keys_rdy_low", 128'(cyc),  128'd10);
        check("b2b_done",         128'(done), 128'd1);
        read_chk(4'd0,  K2,     "b2b_r0");
        read_chk(4'd10, K2_R10, "b2b_r10");

        // Reset in the middle of an expansion.
        start(K1);
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("mid_rst_key_ready",  128'(key_ready),  128'd1);
        check("mid_rst_busy",       128'(busy),       128'd0);
        check("mid_rst_done",       128'(done),       128'd0);
        check("mid_rst_keys_ready", 128'(keys_ready), 128'd0);
        check("mid_rst_rd_key",     rd_key,           128'd0);
        tick();
        tick();
        reset = 1'b1;
        dn = 0;
        repeat (12) begin
            tick();
            if (done) dn++;
        end
        check("mid_rst_no_done",    128'(dn),         128'd0);
        check("mid_rst_keys_idle",  128'(keys_ready), 128'd0);
        start(K1);
        check("rerun_busy", 128'(busy), 128'd1);
        wait_done(cyc);
        check("rerun_latency", 128'(cyc), 128'd10);
        read_chk(4'd1,  K1_R1,  "rerun_r1");
        read_chk(4'd10, K1_R10, "rerun_r10");

        // First edge after reset release accepts a pending key.
        reset     = 1'b0;
        key_in    = K2;
        key_valid = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        key_valid = 1'b0;
        check("rel_accept_busy", 128'(busy), 128'd1);
        wait_done(cyc);
        check("rel_latency", 128'(cyc), 128'd10);
        read_chk(4'd10, K2_R10, "rel_r10");

        // Out-of-range reads.
        read_chk(4'd12, 128'd0, "rd_round_12");
        read_chk(4'd0,  K2,     "rd_round_0_again");
        read_chk(4'd15, 128'd0, "rd_round_15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
